bishop_pst_scorer: RTL and testbench
====================================

# bishop_pst_scorer

Sequential consumer of the bishop piece-square map. Takes the flat 384-bit map bus (64 signed 6-bit entries) plus white and black bishop bitboards, and walks the board LANES squares per cycle. It accumulates white-minus-black positional score and returns it to the evaluator with a start/busy/done handshake. It sits between the bishop map ROM and the evaluation adder tree.

## Interface
Parameters:
- LANES, default 8: squares processed per cycle; legal values 1, 2, 4, 8.
- PST_W, default 6: width of one signed map entry.
- SCORE_W, default 13: signed score width. Covers 2 × 64 × 32 worst case.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: request a scoring pass; accepted only in IDLE.
- whiteBishops, input, 64: bit i = white bishop on square i; latched on accepted start.
- blackBishops, input, 64: bit i = black bishop on square i; latched on accepted start.
- mapIn, input, 384: entry i = mapIn[6i+5:6i], signed. Must be stable while busy; not latched.
- busy, output, 1: high while accumulating.
- done, output, 1: one-cycle pulse when score is updated.
- score, output, SCORE_W: signed white-minus-black sum; held until next done.

## Operation
- States:
  - IDLE: start=1 latches both boards, clears acc and chunk counter, goes to ACCUM.
  - ACCUM: each cycle, processes squares chunk×LANES … chunk×LANES+LANES−1, then increments chunk. After the last chunk (64/LANES − 1), goes to DONE.
  - DONE: score ← acc, done=1, then returns to IDLE.
- Per square s:
  - If white bit s is set, acc += sext(entry[s]).
  - If black bit s is set, acc −= sext(entry[s ^ 56]), i.e. rank-mirrored.
  - Both bits may be set on the same square; each term applies independently.
- All arithmetic is signed, sign-extended to SCORE_W before summing; no saturation needed, since the width covers the range.
- start while busy or in DONE is ignored; no queueing.
- Boards are changeable after the accepting edge without effect.
- Reset at any time: state IDLE, acc 0, chunk 0, score 0, busy 0, done 0. An in-flight pass is discarded and no done is issued.

## Timing
- start sampled high in IDLE at edge T.
- busy=1 for cycles T+1 … T+64/LANES.
- done=1 and new score visible in cycle T+64/LANES+1 (cycle T+9 for LANES=8).
- busy=0 in the DONE cycle.
- Earliest next accepted start is the edge ending the DONE cycle's successor IDLE cycle. Throughput: one pass per 64/LANES+2 cycles.
- score keeps its previous value throughout busy.
- Outputs are registered; no combinational path from start to any output.

## Structure
- Shared include (eval_defs.vh) holds:
  - SQ_COUNT=64, PST_W, SCORE_W, MIRROR_MASK=56.
  - State encodings IDLE/ACCUM/DONE (2-bit).
- One sub-module, pst_lane_sum: combinational.
  - Inputs: LANES white bits, LANES black bits, LANES direct and LANES mirrored entries.
  - Output: signed chunk delta.
- The top level holds the FSM, chunk counter, board registers, acc and score registers.
- Entry selection uses index arithmetic on mapIn: direct via chunk×LANES+k, mirrored via the same index XOR 56.

## Test plan
All scenarios run with the standard bishop map on mapIn and LANES=8.
1. Reset held 3 cycles → score=0, busy=0, done=0. After release with no start, done stays 0 for 20 cycles.
2. White={27}, black={} → busy high cycles T+1..T+8, done pulse exactly at T+9, score=+10.
3. White={2,5} (−20 each), black={58,61} (mirror to 2, 5) → score=0; same run with black={} → score=−40.
4. White={}, black={35} (mirror to 27) → score=−10. Then white=all 64, black={} → score=−200 (map total).
5. start held high continuously → passes complete every 10 cycles. Board changes at T+3 do not alter that pass's score.
6. Reset asserted at T+4 mid-pass → busy=0 next cycle, no done pulse, score=0. A fresh start afterwards scores correctly.

Source files
------------

// File: rtl/bishop_pst_scorer_pkg.sv
// Shared board constants, FSM encoding and square helpers for the bishop
// piece-square scorer.
package bishop_pst_scorer_pkg;

    localparam int SQ_COUNT    = 64;
    localparam int SQ_IDX_W    = 6;
    localparam int MIRROR_MASK = 56;
    localparam int DEF_PST_W   = 6;
    localparam int DEF_SCORE_W = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Flipping the rank bits reads the table from black's point of view.
    function automatic logic [SQ_IDX_W-1:0] mirror_sq(input logic [SQ_IDX_W-1:0] sq);
        return sq ^ SQ_IDX_W'(MIRROR_MASK);
    endfunction

endpackage

// File: rtl/bishop_pst_scorer_if.sv
// Evaluator-side bus of the bishop scorer: boards, map and start/busy/done.
interface bishop_pst_scorer_if
    import bishop_pst_scorer_pkg::*;
#(
    parameter int PST_W   = DEF_PST_W,
    parameter int SCORE_W = DEF_SCORE_W
) ();

    logic                        start;
    logic [SQ_COUNT-1:0]         whiteBishops;
    logic [SQ_COUNT-1:0]         blackBishops;
    logic [SQ_COUNT*PST_W-1:0]   mapIn;
    logic                        busy;
    logic                        done;
    logic signed [SCORE_W-1:0]   score;

    modport master (
        output start, whiteBishops, blackBishops, mapIn,
        input  busy, done, score
    );

    modport slave (
        input  start, whiteBishops, blackBishops, mapIn,
        output busy, done, score
    );

endinterface

// File: rtl/bishop_pst_scorer_lane_sum.sv
// Combinational per-chunk delta: white entries added, mirrored black entries
// subtracted, everything sign-extended to the score width first.
module pst_lane_sum #(
    parameter int LANES   = 8,
    parameter int PST_W   = 6,
    parameter int SCORE_W = 13
) (
    input  logic [LANES-1:0]                   white,
    input  logic [LANES-1:0]                   black,
    input  logic [LANES-1:0][PST_W-1:0]        direct,
    input  logic [LANES-1:0][PST_W-1:0]        mirrored,
    output logic signed [SCORE_W-1:0]          delta
);

    logic signed [LANES-1:0][SCORE_W-1:0] dir_ext;
    logic signed [LANES-1:0][SCORE_W-1:0] mir_ext;

    for (genvar k = 0; k < LANES; k++) begin : g_ext
        assign dir_ext[k] = {{(SCORE_W-PST_W){direct[k][PST_W-1]}}, direct[k]};
        assign mir_ext[k] = {{(SCORE_W-PST_W){mirrored[k][PST_W-1]}}, mirrored[k]};
    end

    // A square holding both colours contributes both terms independently.
    always_comb begin
        delta = '0;
        for (int k = 0; k < LANES; k++) begin
            if (white[k]) delta = delta + $signed(dir_ext[k]);
            if (black[k]) delta = delta - $signed(mir_ext[k]);
        end
    end

endmodule

// File: rtl/bishop_pst_scorer.sv
// Walks the board LANES squares per cycle and returns the white-minus-black
// bishop positional score through a start/busy/done handshake.
module bishop_pst_scorer
    import bishop_pst_scorer_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int PST_W   = DEF_PST_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    bishop_pst_scorer_if.slave bus
);

    localparam int CHUNKS  = SQ_COUNT / LANES;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IDX_W   = $clog2(SQ_COUNT * PST_W);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);

    state_t                    state;
    logic [CHUNK_W-1:0]        chunk;
    logic [SQ_COUNT-1:0]       white_q;
    logic [SQ_COUNT-1:0]       black_q;
    logic signed [SCORE_W-1:0] acc;
    logic signed [SCORE_W-1:0] delta;
    logic signed [SCORE_W-1:0] score_q;
    logic                      busy_q;
    logic                      done_q;

    logic [LANES-1:0]            lane_white;
    logic [LANES-1:0]            lane_black;
    logic [LANES-1:0][PST_W-1:0] lane_direct;
    logic [LANES-1:0][PST_W-1:0] lane_mirror;

    for (genvar k = 0; k < LANES; k++) begin : g_sel
        logic [SQ_IDX_W-1:0] sq;
        logic [SQ_IDX_W-1:0] msq;
        logic [IDX_W-1:0]    dbase;
        logic [IDX_W-1:0]    mbase;

        assign sq    = SQ_IDX_W'(int'(chunk) * LANES + k);
        assign msq   = mirror_sq(sq);
        assign dbase = IDX_W'(sq)  * IDX_W'(PST_W);
        assign mbase = IDX_W'(msq) * IDX_W'(PST_W);

        assign lane_white[k]  = white_q[sq];
        assign lane_black[k]  = black_q[sq];
        assign lane_direct[k] = bus.mapIn[dbase +: PST_W];
        assign lane_mirror[k] = bus.mapIn[mbase +: PST_W];
    end

    pst_lane_sum #(
        .LANES   (LANES),
        .PST_W   (PST_W),
        .SCORE_W (SCORE_W)
    ) u_lane_sum (
        .white    (lane_white),
        .black    (lane_black),
        .direct   (lane_direct),
        .mirrored (lane_mirror),
        .delta    (delta)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            chunk   <= '0;
            acc     <= '0;
            white_q <= '0;
            black_q <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        white_q <= bus.whiteBishops;
                        black_q <= bus.blackBishops;
                        acc     <= '0;
                        chunk   <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc   <= acc + delta;
                    chunk <= chunk + CHUNK_W'(1);
                    // Final sum goes straight to score so it is visible
                    // in the same cycle done is high.
                    if (chunk == LAST_CHUNK) begin
                        score_q <= acc + delta;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.score = score_q;

endmodule

// File: tb/tb_bishop_pst_scorer.sv
// Directed bench for the bishop scorer: stimulus pushes hand-computed scores,
// a negedge monitor pops them whenever done is seen.
module tb_bishop_pst_scorer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bishop_pst_scorer_if #(.PST_W(6), .SCORE_W(13)) bus ();

    bishop_pst_scorer #(.LANES(8), .PST_W(6), .SCORE_W(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Project bishop table, square 0 = a1. Sum of all entries is -200.
    int map_v [64] = '{
        -20, -10, -20, -10, -10, -20, -10, -20,
        -10,   0,   0,   0,   0,   0,   0, -10,
        -10,   0,   5,  10,  10,   5,   0, -10,
        -10,   5,   5,  10,  10,   5,   5, -10,
        -10,   0,  10,  10,  10,  10,   0, -10,
        -10,  10,  10,  10,  10,  10,  10, -10,
        -10,  -5,   0,   0,   0,   0,  -5, -10,
        -20, -10, -20, -10, -10, -20, -10, -20
    };

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got score %0d expected no done", int'(bus.score));
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(bus.score) != e) begin
                    errors++;
                    $display("FAIL score: got %0d expected %0d", int'(bus.score), e);
                end
            end
        end
    end

    function automatic logic [63:0] sq(input int s);
        logic [63:0] one;
        one = 64'd1;
        return one << s;
    endfunction

    // One pass with handshake timing checked: busy for 8 cycles, done at T+9,
    // score unchanged while busy.
    task automatic run_pass(input string name, input logic [63:0] w, input logic [63:0] b,
                            input int exp);
        int n, busy_n, chg_n, prev;
        bit got;
        @(posedge clk); #1;
        bus.whiteBishops = w;
        bus.blackBishops = b;
        bus.start        = 1'b1;
        exp_q.push_back(exp);
        prev = int'(bus.score);
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0; busy_n = 0; chg_n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                check({name, "_busy_in_done"}, int'(bus.busy), 0);
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                if (int'(bus.score) != prev) chg_n++;
            end
        end
        check({name, "_done_seen"}, int'(got), 1);
        check({name, "_latency"}, n, 9);
        check({name, "_busy_cycles"}, busy_n, 8);
        check({name, "_score_held"}, chg_n, 0);
        @(posedge clk);
    endtask

    initial begin
        int done_n, n;
        int done_at[$];

        reset = 1'b1;
        bus.start = 1'b0;
        bus.whiteBishops = '0;
        bus.blackBishops = '0;
        for (int i = 0; i < 64; i++) bus.mapIn[i*6 +: 6] = 6'(map_v[i]);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_score", int'(bus.score), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        done_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
        end
        check("idle_no_done", done_n, 0);

        // Directed passes
        run_pass("w27",        sq(27),          64'd0,           10);
        run_pass("w2_5_b58_61", sq(2) | sq(5),  sq(58) | sq(61), 0);
        run_pass("w2_5",       sq(2) | sq(5),   64'd0,           -40);
        run_pass("b35",        64'd0,           sq(35),          -10);
        run_pass("w_all",      '1,              64'd0,           -200);
        run_pass("b_all",      64'd0,           '1,              200);
        run_pass("both49",     sq(49),          sq(49),          -5);

        // start held high: back-to-back passes, board change mid-pass ignored
        @(posedge clk); #1;
        bus.whiteBishops = sq(27);
        bus.blackBishops = '0;
        bus.start = 1'b1;
        exp_q.push_back(10);
        exp_q.push_back(-20);
        exp_q.push_back(-20);
        @(posedge clk);                      // edge T
        repeat (3) @(posedge clk);
        #1;
        bus.whiteBishops = sq(2);
        n = 3;
        while (n < 60 && done_at.size() < 3) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                done_at.push_back(n);
                if (done_at.size() == 3) bus.start = 1'b0;
            end
        end
        check("b2b_done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("b2b_first", done_at[0], 9);
            check("b2b_period1", done_at[1] - done_at[0], 10);
            check("b2b_period2", done_at[2] - done_at[1], 10);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-pass discards the pass
        @(posedge clk); #1;
        bus.whiteBishops = '1;
        bus.blackBishops = '0;
        bus.start = 1'b1;
        @(posedge clk); #1;                  // edge T
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;                  // edge T+4
        reset = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_score", int'(bus.score), 0);
        done_n = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
        end
        check("midrst_no_done", done_n, 0);
        run_pass("after_rst", '1, 64'd0, -200);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
